// File: rtl/key_mode_ctrl_if.sv
// Key-to-LED mode bus: debounced press pulse in, current mode and LED drive out.
interface key_mode_ctrl_if;
    logic       key_flag;
    logic [1:0] mode;
    logic [3:0] led_out;

    modport master (output key_flag, input mode, led_out);
    modport slave  (input key_flag, output mode, led_out);
endinterface

// File: rtl/key_mode_ctrl.sv
// Key-driven 4-mode LED controller (off / on / running light / blink) with a step timer.
// Optional auto-return to OFF after IDLE_MAX idle step ticks when KEY_IDLE_RET_EN is defined.
module key_mode_ctrl #(
    parameter logic [24:0] CNT_MAX  = 25'd24_999_999,
    parameter logic [7:0]  IDLE_MAX = 8'd20
) (
    input logic            sys_clk,
    input logic            sys_rst_n,
    key_mode_ctrl_if.slave bus
);
    localparam int unsigned CNT_W  = 25;
    localparam int unsigned LED_W  = 4;
    localparam int unsigned IDLE_W = 8;

    typedef enum logic [1:0] {
        M_OFF   = 2'd0,
        M_ON    = 2'd1,
        M_FLOW  = 2'd2,
        M_BLINK = 2'd3
    } mode_e;

    mode_e              state_q, state_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               step_tick_c;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            M_OFF:   next_mode = M_ON;
            M_ON:    next_mode = M_FLOW;
            M_FLOW:  next_mode = M_BLINK;
            default: next_mode = M_OFF;
        endcase
    endfunction

    function automatic logic [LED_W-1:0] entry_led(input mode_e m);
        case (m)
            M_ON:    entry_led = 4'b1111;
            M_FLOW:  entry_led = 4'b0001;
            M_BLINK: entry_led = 4'b1111;
            default: entry_led = 4'b0000;
        endcase
    endfunction

    assign step_tick_c = (cnt_q == CNT_MAX);

`ifdef KEY_IDLE_RET_EN
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              idle_expire_c;

    // Expiry on the IDLE_MAX-th consecutive tick without a press outside OFF
    assign idle_expire_c = step_tick_c && (state_q != M_OFF) &&
                           ((9'({1'b0, idle_q}) + 9'd1) >= 9'({1'b0, IDLE_MAX}));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    always_comb begin
        idle_d = idle_q;
        if (bus.key_flag || (state_q == M_OFF) || idle_expire_c) begin
            idle_d = '0;
        end else if (step_tick_c) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end
`else
    logic unused_idle_max;
    assign unused_idle_max = ^IDLE_MAX;
`endif

    // State, pattern and step timer registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= M_OFF;
            led_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            cnt_q   <= cnt_d;
        end
    end

    // Key press beats a coincident step tick; the tick advances the pattern
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        cnt_d   = cnt_q + CNT_W'(1);

        if (step_tick_c) begin
            cnt_d = '0;
        end

        if (bus.key_flag) begin
            state_d = next_mode(state_q);
            led_d   = entry_led(next_mode(state_q));
            cnt_d   = '0;
        end else if (step_tick_c) begin
            case (state_q)
                M_FLOW:  led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                M_BLINK: led_d = ~led_q;
                default: led_d = led_q;
            endcase
`ifdef KEY_IDLE_RET_EN
            if (idle_expire_c) begin
                state_d = M_OFF;
                led_d   = '0;
            end
`endif
        end
    end

    assign bus.mode    = state_q;
    assign bus.led_out = led_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Self-checking bench for key_mode_ctrl: elapsed-time model plus directed literal checks.
module tb_key_mode_ctrl;
    localparam logic [24:0] CNT_MAX  = 25'd4;
    localparam logic [7:0]  IDLE_MAX = 8'd3;
    localparam int          P        = 5;
    localparam int          IDLE_N   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    key_mode_ctrl_if bus ();

    key_mode_ctrl #(.CNT_MAX(CNT_MAX), .IDLE_MAX(IDLE_MAX)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: mode plus clocks elapsed since the last press decide everything
    int m_mode = 0;
    int m_el   = 0;
    int nm, ne;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0;
            m_el   <= 0;
        end else begin
            if (bus.key_flag) begin
                nm = (m_mode + 1) % 4;
                ne = 0;
            end else begin
                nm = m_mode;
                ne = m_el + 1;
            end
`ifdef KEY_IDLE_RET_EN
            if (nm != 0 && ne >= IDLE_N * P) nm = 0;
`endif
            m_mode <= nm;
            m_el   <= ne;
        end
    end

    function automatic int exp_led(input int md, input int el);
        int k;
        k = el / P;
        case (md)
            1:       return 'hF;
            2:       return 1 << (k % 4);
            3:       return ((k % 2) == 0) ? 'hF : 0;
            default: return 0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_mode", int'(bus.mode), m_mode);
            check("model_led", int'(bus.led_out), exp_led(m_mode, m_el));
        end
    end

    task automatic press();
        bus.key_flag = 1'b1;
        @(negedge clk);
        bus.key_flag = 1'b0;
    endtask

    initial begin
        bus.key_flag = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_mode", int'(bus.mode), 0);
        check("reset_led", int'(bus.led_out), 0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_off_mode", int'(bus.mode), 0);
        check("idle_off_led", int'(bus.led_out), 0);

`ifndef KEY_IDLE_RET_EN
        press();
        check("on_mode", int'(bus.mode), 1);
        check("on_led", int'(bus.led_out), 'hF);
        repeat (50) @(negedge clk);
        check("on_hold_led", int'(bus.led_out), 'hF);

        press();
        check("flow_mode", int'(bus.mode), 2);
        check("flow_led0", int'(bus.led_out), 'h1);
        repeat (5) @(negedge clk);
        check("flow_led5", int'(bus.led_out), 'h2);
        repeat (5) @(negedge clk);
        check("flow_led10", int'(bus.led_out), 'h4);
        repeat (5) @(negedge clk);
        check("flow_led15", int'(bus.led_out), 'h8);
        repeat (5) @(negedge clk);
        check("flow_led20", int'(bus.led_out), 'h1);

        press();
        check("blink_mode", int'(bus.mode), 3);
        check("blink_led0", int'(bus.led_out), 'hF);
        repeat (5) @(negedge clk);
        check("blink_led5", int'(bus.led_out), 'h0);
        repeat (5) @(negedge clk);
        check("blink_led10", int'(bus.led_out), 'hF);

        press();
        check("wrap_mode", int'(bus.mode), 0);
        check("wrap_led", int'(bus.led_out), 0);
`endif

        // Press exactly on a FLOW step tick
        press();
        press();
        check("flow2_mode", int'(bus.mode), 2);
        repeat (4) @(negedge clk);
        check("pre_tick_led", int'(bus.led_out), 'h1);
        press();
        check("tick_key_mode", int'(bus.mode), 3);
        check("tick_key_led", int'(bus.led_out), 'hF);
        repeat (4) @(negedge clk);
        check("tick_key_led4", int'(bus.led_out), 'hF);
        @(negedge clk);
        check("tick_key_led5", int'(bus.led_out), 'h0);

        // Asynchronous reset mid-BLINK
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mode", int'(bus.mode), 0);
        check("async_rst_led", int'(bus.led_out), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Key held three cycles advances three modes
        bus.key_flag = 1'b1;
        repeat (3) @(negedge clk);
        bus.key_flag = 1'b0;
        check("held_mode", int'(bus.mode), 3);
        check("held_led", int'(bus.led_out), 'hF);
        press();
        check("held_wrap_mode", int'(bus.mode), 0);

        // Idle auto-return window
        @(negedge clk);
        press();
        check("idle_enter_mode", int'(bus.mode), 1);
        repeat (14) @(negedge clk);
        check("idle_14_mode", int'(bus.mode), 1);
        @(negedge clk);
`ifdef KEY_IDLE_RET_EN
        check("idle_15_mode", int'(bus.mode), 0);
        check("idle_15_led", int'(bus.led_out), 0);
`else
        check("idle_15_mode", int'(bus.mode), 1);
        check("idle_15_led", int'(bus.led_out), 'hF);
`endif
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/key_mode_ctrl.md
# key_mode_ctrl

Consumes the debounced single-cycle `key_flag` pulse from the key debounce stage. Each pulse advances a 4-state LED display mode: off, all on, running light, blink. Drives a 4-bit LED bank with patterns timed by an internal step timer, so each board key press gives a visible, deterministic response.

## Interface
Parameters:
- `CNT_MAX`, default 25'd24_999_999: step timer terminal count. Step period is CNT_MAX+1 clocks (500 ms at 50 MHz).
- `IDLE_MAX`, default 8'd20: number of step ticks without a key press before auto-return to mode 0. Used only when `KEY_IDLE_RET_EN` is defined.

Ports:
- `sys_clk` in 1: system clock; all logic on its rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `key_flag` in 1: debounced press pulse, one clock wide, synchronous to `sys_clk`.
- `mode` out 2: current display mode, registered.
- `led_out` out 4: LED drive, registered, 1 = lit.

## Operation
Reset values:
- `mode` = 2'd0, `led_out` = 4'b0000.
- Step counter = 0; idle counter = 0.

Step timer (`cnt_step`, 25 bits):
- Counts 0..CNT_MAX. The step tick is the cycle where `cnt_step` == CNT_MAX. On that cycle the counter wraps to 0.
- Cleared to 0 on `key_flag`, so a new mode always starts a full step period.
- Runs in every mode.

Mode sequence, advancing on `key_flag`:
- 0 OFF → 1 ON → 2 FLOW → 3 BLINK → 0 OFF.
- `mode` wraps modulo 4.

`led_out` per mode:
- OFF: 4'b0000, held.
- ON: 4'b1111, held.
- FLOW: enters at 4'b0001. Rotates left one position per step tick: 0001→0010→0100→1000→0001.
- BLINK: enters at 4'b1111. Inverts on each step tick (1111↔0000).

On `key_flag`, all of the following happen in the same edge:
- `mode` <= mode+1.
- `led_out` <= entry pattern of the new mode.
- `cnt_step` <= 0.

Simultaneous events:
- `key_flag` and a step tick in the same cycle: `key_flag` wins. The pattern does not advance.
- `key_flag` held high for consecutive cycles (out-of-contract input): advances one mode per cycle. No extra protection.

Reset asserted mid-operation: all state returns immediately (asynchronously) to reset values. After release, operation restarts from OFF with the timer at 0.

## Timing
- `key_flag` high in cycle N → new `mode` and entry `led_out` visible after edge N+1 (latency 1 clock).
- First pattern update after a key press: CNT_MAX+1 clocks after that press. Subsequent updates follow every CNT_MAX+1 clocks.
- FLOW full cycle: 4×(CNT_MAX+1) clocks. BLINK full period: 2×(CNT_MAX+1) clocks.
- Outputs are glitch-free; all outputs are registered.

## Configuration
- `KEY_IDLE_RET_EN` defined:
  - An 8-bit idle counter increments on each step tick while `mode` != 0. It clears on `key_flag` and while in mode 0.
  - On the IDLE_MAX-th consecutive tick with no press: `mode` <= 0, `led_out` <= 4'b0000, idle counter <= 0.
  - If `key_flag` coincides with that tick, `key_flag` wins; normal advance applies.
- `KEY_IDLE_RET_EN` undefined:
  - No idle counter; `IDLE_MAX` is ignored.
  - Mode changes only on `key_flag`.

## Test plan
All scenarios use CNT_MAX=4 (5-clock step).
- Reset: assert `sys_rst_n`=0 → `mode`=0, `led_out`=0000. Release with no key → outputs unchanged for 100 clocks.
- One `key_flag` pulse → next edge `mode`=1, `led_out`=1111; held for 50 clocks.
- Second pulse → `mode`=2, `led_out`=0001. Then 0010, 0100, 1000 at +5, +10, +15 clocks; back to 0001 at +20 clocks.
- Third pulse → `mode`=3, `led_out`=1111, then 0000 at +5, 1111 at +10. Fourth pulse → `mode`=0, `led_out`=0000.
- In FLOW, pulse `key_flag` on the tick cycle (`cnt_step`=4) → `mode`=3, `led_out`=1111, no rotation; next toggle 5 clocks later. Reset mid-BLINK → immediate `mode`=0, `led_out`=0000.
- With `KEY_IDLE_RET_EN` and IDLE_MAX=3: enter mode 1, no further presses → `mode`=0, `led_out`=0000 exactly 15 clocks after the press. Without the macro → `mode` stays 1.
